// File: rtl/cassette_rec.sv
// cassette_rec: demodulates 1200/2400 Hz FSK cassette audio into bytes aligned on the 0x55 leader
// and streams them into SDRAM over a req/ack port; define CAS_REC_EOF_EN to auto-stop on the CoCo EOF block.
module cassette_rec #(
  parameter int PERIOD_SPLIT = 31818,
  parameter int MIN_PERIOD   = 8000,
  parameter int TIMEOUT      = 60000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        record,
  input  logic        rewind,
  input  logic        cas_in,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_data,
  output logic        sdram_wr,
  input  logic        sdram_ack,
  output logic [2:0]  status
);
  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, LOCKED = 2'd2} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_sync;
  logic        r_rise, r_rec_d, r_rew_d, r_ovf;
  logic [15:0] r_cnt;
  logic [7:0]  r_shift;
  logic [2:0]  r_bits;
  logic        w_rec_edge, w_rew_edge, w_timeout, w_accept, w_match, w_emit, w_eof;
  logic [7:0]  w_shift;

  assign w_rec_edge = record & ~r_rec_d;
  assign w_rew_edge = rewind ^ r_rew_d;
  assign w_timeout  = r_cnt == 16'(TIMEOUT);
  assign w_accept   = r_rise && r_cnt >= 16'(MIN_PERIOD);
  assign w_shift    = {r_cnt < 16'(PERIOD_SPLIT), r_shift[7:1]};
  assign w_match    = r_state == HUNT && w_accept && w_shift == 8'h55;
  // Bytes are suppressed on the cycle a control edge or silence reshapes the state.
  assign w_emit     = !w_rew_edge && !w_rec_edge && !w_timeout && w_accept &&
                      (w_match || (r_state == LOCKED && r_bits == 3'd7));
  assign status     = {r_ovf, r_state};

`ifdef CAS_REC_EOF_EN
  logic [47:0] r_hist;
  assign w_eof = sdram_wr && sdram_ack && {r_hist[39:0], sdram_data} == 48'h55_3C_FF_00_FF_55;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_hist <= '0;
    else if (w_rew_edge || (w_rec_edge && r_state == IDLE)) r_hist <= '0;
    else if (sdram_wr && sdram_ack) r_hist <= {r_hist[39:0], sdram_data};
`else
  assign w_eof = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_rew_edge) w_next = IDLE;
    else if (w_rec_edge) w_next = (r_state == IDLE) ? HUNT : IDLE;
    else if (w_eof) w_next = IDLE;
    else if (r_state != IDLE && w_timeout) w_next = HUNT;
    else if (w_match) w_next = LOCKED;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_rise     <= 1'b0;
      r_rec_d    <= 1'b0;
      r_rew_d    <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_bits     <= '0;
      r_ovf      <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_wr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], cas_in};
      r_rise  <= r_sync[1] & ~r_sync[2];
      r_rec_d <= record;
      r_rew_d <= rewind;
      r_cnt   <= w_accept ? 16'd0 : (w_timeout ? r_cnt : r_cnt + 16'd1);
      if (w_rew_edge || w_rec_edge || (r_state != IDLE && w_timeout)) begin
        r_shift <= '0;
        r_bits  <= '0;
      end else if (w_accept && r_state != IDLE) begin
        r_shift <= w_shift;
        r_bits  <= (r_state == LOCKED) ? r_bits + 3'd1 : 3'd0;
      end
      if (w_rew_edge) begin
        sdram_addr <= '0;
        sdram_wr   <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        if (sdram_wr && sdram_ack) begin
          sdram_wr   <= 1'b0;
          sdram_addr <= sdram_addr + 25'd1;
        end
        if (w_emit && sdram_wr) r_ovf <= 1'b1;
        else if (w_emit) begin
          sdram_data <= w_shift;
          sdram_wr   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cassette_rec.sv
// tb_cassette_rec: randomized FSK bursts decoded by a bit-stream reference model and
// compared against the observed SDRAM write stream.
module tb_cassette_rec;
  logic        clk = 1'b0, reset_n = 1'b0, record = 1'b0, rewind = 1'b0, cas_in = 1'b0, sdram_ack = 1'b0;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_wr;
  logic [2:0]  status;
  int          checks = 0, errors = 0, dly = 0;
  logic        ack_en = 1'b0;
  logic        bits[$];
  logic [7:0]  exp_q[$];
  logic [32:0] obs_q[$];
  logic [24:0] exp_addr = '0, a0;
  logic [2:0]  eof_st, after_st, tog_st;

  cassette_rec #(.PERIOD_SPLIT(30), .MIN_PERIOD(8), .TIMEOUT(100)) dut (
    .clk(clk), .reset_n(reset_n), .record(record), .rewind(rewind), .cas_in(cas_in),
    .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_wr(sdram_wr),
    .sdram_ack(sdram_ack), .status(status)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    if (sdram_ack) sdram_ack = 1'b0;
    else if (sdram_wr && ack_en) begin
      if (dly == 0) begin
        sdram_ack = 1'b1;
        dly = $urandom_range(0, 3);
      end else dly--;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sdram_wr && sdram_ack) obs_q.push_back({sdram_addr, sdram_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    int p;
    p = b ? int'($urandom_range(16, 24)) : int'($urandom_range(38, 56));
    bits.push_back(b);
    if (glitch) begin
      wait_n(3); cas_in = 1'b0; wait_n(2); cas_in = 1'b1; wait_n(p / 2 - 5);
    end else wait_n(p / 2);
    cas_in = 1'b0;
    wait_n(p - p / 2);
    cas_in = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gb);
    for (int k = 0; k < 8; k++) send_bit(b[k], k == gb);
  endtask

  task automatic start_burst;
    cas_in = 1'b1;
  endtask

  // Leader search then fixed 8-bit framing, straight from the bit stream that was sent.
  task automatic decode;
    int i;
    logic found;
    logic [7:0] v;
    i = 0;
    found = 1'b0;
    while (i + 8 <= bits.size()) begin
      for (int k = 0; k < 8; k++) v[k] = bits[i + k];
      if (found || v == 8'h55) begin
        exp_q.push_back(v);
        found = 1'b1;
        i += 8;
      end else i++;
    end
    bits.delete();
  endtask

  task automatic check_writes;
    logic [7:0] e;
    logic [32:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("write_present", obs_q.size() > 0, 1);
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front();
      chk("wdata", o[7:0], e);
      chk("waddr", o[32:8], exp_addr);
      exp_addr = exp_addr + 25'd1;
    end
    exp_q.delete();
    chk("extra_writes", obs_q.size(), 0);
  endtask

  task automatic end_burst(input logic score);
    wait_n(10);
    cas_in = 1'b0;
    wait_n(160);
    if (score) begin
      decode();
      check_writes();
    end else bits.delete();
  endtask

  task automatic pulse_rec;
    record = 1'b1; wait_n(2); record = 1'b0; wait_n(3);
  endtask

  task automatic pulse_rew;
    rewind = 1'b1; wait_n(3); rewind = 1'b0; wait_n(3);
  endtask

  initial begin
    int gr;
`ifdef CAS_REC_EOF_EN
    eof_st = 3'b000; after_st = 3'b000; tog_st = 3'b001;
`else
    eof_st = 3'b010; after_st = 3'b001; tog_st = 3'b000;
`endif
    wait_n(3);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_data", sdram_data, 0);
    chk("rst_wr", sdram_wr, 0);
    chk("rst_status", status, 0);
    reset_n = 1'b1;
    wait_n(150);
    chk("idle_after_reset", status, 3'b000);
    pulse_rec();
    chk("hunt_after_record", status, 3'b001);
    ack_en = 1'b1;
    start_burst();
    for (int n = 0; n < 16; n++) send_byte(8'h55, -1);
    wait_n(5);
    chk("locked_after_leader", status, 3'b010);
    send_byte(8'h3C, -1);
    send_byte(8'hA5, -1);
    gr = $urandom_range(0, 3);
    for (int n = 0; n < 4; n++) send_byte(8'($urandom), n == gr ? int'($urandom_range(0, 7)) : -1);
    end_burst(1);
    chk("addr_after_burst1", sdram_addr, 22);
    chk("hunt_after_silence", status, 3'b001);
    ack_en = 1'b0;
    a0 = sdram_addr;
    start_burst();
    send_byte(8'h55, -1);
    send_byte(8'h11, -1);
    send_byte(8'h22, -1);
    end_burst(0);
    chk("ovf_wr_held", sdram_wr, 1);
    chk("ovf_data_kept", sdram_data, 8'h55);
    chk("ovf_addr_held", sdram_addr, a0);
    chk("ovf_status", status, 3'b101);
    ack_en = 1'b1;
    wait_n(10);
    chk("ovf_wr_done", sdram_wr, 0);
    chk("ovf_addr_inc", sdram_addr, a0 + 25'd1);
    exp_q.push_back(8'h55);
    check_writes();
    start_burst();
    send_byte(8'h55, -1);
    send_byte(8'h55, -1);
    for (int k = 0; k < 4; k++) send_bit(1'($urandom), 1'b0);
    end_burst(1);
    chk("timeout_hunt", status, 3'b101);
    start_burst();
    send_byte(8'h55, -1);
    send_byte(8'h12, -1);
    end_burst(1);
    pulse_rew();
    chk("rew_addr", sdram_addr, 0);
    chk("rew_status", status, 0);
    chk("rew_wr", sdram_wr, 0);
    exp_addr = '0;
    pulse_rec();
    chk("hunt_again", status, 3'b001);
    start_burst();
    send_byte(8'h55, -1);
    send_byte(8'h3C, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h00, -1);
    send_byte(8'hFF, -1);
    send_byte(8'h55, -1);
    wait_n(15);
    chk("eof_state", status, eof_st);
    end_burst(1);
    chk("eof_addr", sdram_addr, 6);
    chk("state_after_eof_silence", status, after_st);
    pulse_rec();
    chk("record_toggle", status, tog_st);
    record = 1'b1;
    rewind = 1'b1;
    wait_n(3);
    chk("rewind_wins_status", status, 0);
    chk("rewind_wins_addr", sdram_addr, 0);
    record = 1'b0;
    rewind = 1'b0;
    wait_n(3);
    chk("final_idle", status, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
